// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the reg_bank register file and its clear sequencer.
package reg_bank_pkg;

  typedef enum logic {RB_IDLE, RB_CLEARING} rb_state_t;

  localparam int RB_WIDTH = 16;
  localparam int RB_DEPTH = 8;

endpackage

// File: rtl/reg_bank_if.sv
// Write/read/clear bus of reg_bank; master drives requests, slave is the bank.
interface reg_bank_if
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = RB_WIDTH,
  parameter int DEPTH = RB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             clear_req;
  logic             busy;
  logic             clear_done;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, clear_req,
    input  rdata_a, rdata_b, busy, clear_done
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, clear_req,
    output rdata_a, rdata_b, busy, clear_done
  );

endinterface

// File: rtl/rb_clear_seq.sv
// Bulk-clear sequencer: sweeps one entry per cycle from 0 to DEPTH-1, then pulses clear_done.
module rb_clear_seq
  import reg_bank_pkg::*;
#(
  parameter int DEPTH = RB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          clear_req,
  output logic          busy,
  output logic          clear_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rb_state_t     state;
  logic [AW-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= RB_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        RB_IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state <= RB_CLEARING;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RB_CLEARING: begin
          // Requests arriving mid-sweep are ignored; the last-index compare ends the sweep.
          if (cnt == LAST_IDX) begin
            state      <= RB_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          state      <= RB_IDLE;
          cnt        <= '0;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank: one write port, two combinational read ports, sequenced bulk clear.
// Optional same-cycle write-through forwarding to the read ports under `REG_BANK_BYPASS_EN.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = RB_WIDTH,
  parameter int DEPTH = RB_DEPTH
) (
  input  logic        Clk,
  input  logic        Reset_n,
  reg_bank_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_en;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  rb_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear_req  (bus.clear_req),
    .busy       (bus.busy),
    .clear_done (bus.clear_done),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr)
  );

  // Writes only land while idle; during a sweep they are dropped rather than queued.
  assign wr_en = bus.we && !clr_we;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    rd_a = mem[bus.raddr_a];
    rd_b = mem[bus.raddr_b];
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && (bus.raddr_a == bus.waddr)) rd_a = bus.wdata;
    if (wr_en && (bus.raddr_b == bus.waddr)) rd_b = bus.wdata;
`endif
  end

  assign bus.rdata_a = rd_a;
  assign bus.rdata_b = rd_b;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (8 x 16), one task per scenario.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic Clk;
  logic Reset_n;
  int   tests_run;
  int   tests_failed;

  reg_bank_if #(.WIDTH(16), .DEPTH(8)) bus ();

  reg_bank #(.WIDTH(16), .DEPTH(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    @(negedge Clk);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    step();
    bus.we = 1'b0;
  endtask

  task automatic fill_a0();
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'h00A0 + 16'(i));
  endtask

  task automatic pulse_clear();
    @(negedge Clk);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b, required 0/0", bus.busy, bus.clear_done);
    end
    for (int i = 0; i < 8; i++) begin
      bus.raddr_a = 3'(i);
      #1;
      tests_run++;
      if (bus.rdata_a !== 16'h0) begin
        tests_failed++;
        $display("FAIL reset_mem[%0d]: got %h, required 0000", i, bus.rdata_a);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    bus.raddr_a = 3'd3;
    bus.raddr_b = 3'd5;
    write_word(3'd3, 16'h1234);
    tests_run++;
    if (bus.rdata_a !== 16'h1234) begin
      tests_failed++;
      $display("FAIL wr_a3: got %h, required 1234", bus.rdata_a);
    end
    write_word(3'd5, 16'hBEEF);
    tests_run++;
    if (bus.rdata_b !== 16'hBEEF || bus.rdata_a !== 16'h1234) begin
      tests_failed++;
      $display("FAIL wr_b5: a=%h b=%h, required 1234/beef", bus.rdata_a, bus.rdata_b);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    int done_cnt;
    int done_ok;
    fill_a0();
    bus.raddr_a = 3'd6;
    bus.raddr_b = 3'd1;
    #1;
    tests_run++;
    if (bus.rdata_a !== 16'h00A6 || bus.rdata_b !== 16'h00A1) begin
      tests_failed++;
      $display("FAIL fill: a=%h b=%h, required 00a6/00a1", bus.rdata_a, bus.rdata_b);
    end
    pulse_clear();
    busy_cnt = 0;
    done_cnt = 0;
    done_ok  = 1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.clear_done === 1'b1) begin
        done_cnt++;
        if (bus.busy !== 1'b0 || k != 8) done_ok = 0;
      end
    end
    tests_run++;
    if (busy_cnt != 8) begin
      tests_failed++;
      $display("FAIL clear_busy_len: got %0d cycles, required 8", busy_cnt);
    end
    tests_run++;
    if (done_cnt != 1 || done_ok != 1) begin
      tests_failed++;
      $display("FAIL clear_done_pulse: got %0d pulses (timing ok=%0d), required 1 at busy fall", done_cnt, done_ok);
    end
    for (int i = 0; i < 8; i++) begin
      bus.raddr_a = 3'(i);
      bus.raddr_b = 3'(7 - i);
      #1;
      tests_run++;
      if (bus.rdata_a !== 16'h0 || bus.rdata_b !== 16'h0) begin
        tests_failed++;
        $display("FAIL cleared[%0d]: a=%h b=%h, required 0000", i, bus.rdata_a, bus.rdata_b);
      end
    end
  endtask

  task automatic test_write_during_clear();
    int k_done;
    fill_a0();
    pulse_clear();
    step();
    step();
    // Third sweep cycle: entries 0 and 1 are zeroed, the rest untouched.
    bus.raddr_a = 3'd1;
    bus.raddr_b = 3'd5;
    #1;
    tests_run++;
    if (bus.rdata_a !== 16'h0 || bus.rdata_b !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL partial_clear: a=%h b=%h, required 0000/00a5", bus.rdata_a, bus.rdata_b);
    end
    bus.we    = 1'b1;
    bus.waddr = 3'd7;
    bus.wdata = 16'hFFFF;
    step();
    bus.waddr     = 3'd0;
    bus.clear_req = 1'b1;
    step();
    bus.we        = 1'b0;
    bus.clear_req = 1'b0;
    k_done = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.clear_done === 1'b1) begin
        k_done = k;
        break;
      end
    end
    tests_run++;
    if (k_done != 3) begin
      tests_failed++;
      $display("FAIL sweep_end: done after %0d cycles, required 3", k_done);
    end
    step();
    bus.raddr_a = 3'd7;
    bus.raddr_b = 3'd0;
    #1;
    tests_run++;
    if (bus.rdata_a !== 16'h0 || bus.rdata_b !== 16'h0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL dropped_write: a7=%h b0=%h busy=%b, required 0000/0000/0", bus.rdata_a, bus.rdata_b, bus.busy);
    end
  endtask

  task automatic test_write_with_clear();
    bus.raddr_a = 3'd2;
    @(negedge Clk);
    bus.we        = 1'b1;
    bus.waddr     = 3'd2;
    bus.wdata     = 16'h5555;
    bus.clear_req = 1'b1;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wc_busy_before: got %b, required 0", bus.busy);
    end
    step();
    bus.we        = 1'b0;
    bus.clear_req = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.rdata_a !== 16'h5555) begin
      tests_failed++;
      $display("FAIL wc_priority: busy=%b a2=%h, required 1/5555", bus.busy, bus.rdata_a);
    end
    repeat (9) step();
    tests_run++;
    if (bus.rdata_a !== 16'h0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wc_swept: a2=%h busy=%b, required 0000/0", bus.rdata_a, bus.busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_seen;
    fill_a0();
    pulse_clear();
    repeat (3) step();
    #2;
    Reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ctrl: busy=%b done=%b, required 0/0", bus.busy, bus.clear_done);
    end
    for (int i = 0; i < 8; i++) begin
      bus.raddr_b = 3'(i);
      #1;
      tests_run++;
      if (bus.rdata_b !== 16'h0) begin
        tests_failed++;
        $display("FAIL abort_mem[%0d]: got %h, required 0000", i, bus.rdata_b);
      end
    end
    @(negedge Clk);
    Reset_n   = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.clear_done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
    end
    tests_run++;
    if (done_seen != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: %0d cycles with busy/done set, required 0", done_seen);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_now;
    write_word(3'd4, 16'h1111);
`ifdef REG_BANK_BYPASS_EN
    exp_now = 16'hCAFE;
`else
    exp_now = 16'h1111;
`endif
    @(negedge Clk);
    bus.raddr_a = 3'd4;
    bus.raddr_b = 3'd3;
    bus.we      = 1'b1;
    bus.waddr   = 3'd4;
    bus.wdata   = 16'hCAFE;
    #1;
    tests_run++;
    if (bus.rdata_a !== exp_now || bus.rdata_b !== 16'h0) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: a=%h b=%h, required %h/0000", bus.rdata_a, bus.rdata_b, exp_now);
    end
    step();
    bus.we = 1'b0;
    tests_run++;
    if (bus.rdata_a !== 16'hCAFE) begin
      tests_failed++;
      $display("FAIL bypass_next_cycle: got %h, required cafe", bus.rdata_a);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    Reset_n       = 1'b1;
    bus.we        = 1'b0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.raddr_a   = '0;
    bus.raddr_b   = '0;
    bus.clear_req = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_clear();
    test_write_during_clear();
    test_write_with_clear();
    test_reset_mid_sweep();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
